// File: rtl/sap_control_sequencer_if.sv
// Control bundle between the SAP sequencer and the datapath: decode inputs in,
// bus-control strobes out.
interface sap_control_sequencer_if;
    logic       Enable;
    logic [3:0] Opcode;
    logic [1:0] Flags;
    logic       PCOut;
    logic       PCInc;
    logic       PCLoad;
    logic       MARIn;
    logic       RAMOut;
    logic       RAMIn;
    logic       IRIn;
    logic       IROut;
    logic       AIn;
    logic       AOut;
    logic       BIn;
    logic       ALUOut;
    logic [1:0] Operation;
    logic       FlagsIn;
    logic       OutIn;
    logic       Halt;
    logic [2:0] TState;

    modport master (
        input  Enable, Opcode, Flags,
        output PCOut, PCInc, PCLoad, MARIn, RAMOut, RAMIn, IRIn, IROut,
        output AIn, AOut, BIn, ALUOut, Operation, FlagsIn, OutIn, Halt, TState
    );

    modport slave (
        output Enable, Opcode, Flags,
        input  PCOut, PCInc, PCLoad, MARIn, RAMOut, RAMIn, IRIn, IROut,
        input  AIn, AOut, BIn, ALUOut, Operation, FlagsIn, OutIn, Halt, TState
    );
endinterface

// File: rtl/sap_control_sequencer.sv
// SAP fetch/decode/execute sequencer: T-state ring plus combinational strobe
// decode of (T-state, opcode, flags), with a sticky halt cleared only by reset.
module sap_control_sequencer #(
    parameter int unsigned NUM_T = 6
) (
    input  logic                           clk,
    input  logic                           rst,
    sap_control_sequencer_if.master        bus
);

    typedef enum logic [2:0] {StT0, StT1, StT2, StT3, StT4, StT5} tstate_e;

    localparam logic [3:0] OpNop = 4'b0000;
    localparam logic [3:0] OpLda = 4'b0001;
    localparam logic [3:0] OpAdd = 4'b0010;
    localparam logic [3:0] OpSub = 4'b0011;
    localparam logic [3:0] OpSta = 4'b0100;
    localparam logic [3:0] OpLdi = 4'b0101;
    localparam logic [3:0] OpJmp = 4'b0110;
    localparam logic [3:0] OpJc  = 4'b0111;
    localparam logic [3:0] OpJz  = 4'b1000;
    localparam logic [3:0] OpInc = 4'b1001;
    localparam logic [3:0] OpDcr = 4'b1010;
    localparam logic [3:0] OpOut = 4'b1110;
    localparam logic [3:0] OpHlt = 4'b1111;

    localparam logic [2:0] LastT = 3'(NUM_T - 1);

    tstate_e    state_q;
    logic       halted_q;
    logic [2:0] last_step;

    // Final execute step per opcode; everything not listed ends at T2.
    always_comb begin
        last_step = 3'd2;
        case (bus.Opcode)
            OpLda, OpSta: last_step = 3'd3;
            OpAdd, OpSub: last_step = 3'd4;
            default:      last_step = 3'd2;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StT0;
            halted_q <= 1'b0;
        end else if (halted_q) begin
            state_q <= StT0;
        end else if (bus.Enable) begin
            if (state_q == tstate_e'(LastT)) begin
                state_q <= StT0;
            end else if (state_q >= StT2 && state_q >= tstate_e'(last_step)) begin
                state_q <= StT0;
                if (state_q == StT2 && bus.Opcode == OpHlt) halted_q <= 1'b1;
            end else begin
                state_q <= tstate_e'(state_q + 3'd1);
            end
        end
    end

    assign bus.TState = state_q;
    assign bus.Halt   = halted_q;

    always_comb begin
        bus.PCOut     = 1'b0;
        bus.PCInc     = 1'b0;
        bus.PCLoad    = 1'b0;
        bus.MARIn     = 1'b0;
        bus.RAMOut    = 1'b0;
        bus.RAMIn     = 1'b0;
        bus.IRIn      = 1'b0;
        bus.IROut     = 1'b0;
        bus.AIn       = 1'b0;
        bus.AOut      = 1'b0;
        bus.BIn       = 1'b0;
        bus.ALUOut    = 1'b0;
        bus.Operation = 2'b00;
        bus.FlagsIn   = 1'b0;
        bus.OutIn     = 1'b0;
        // Reset is checked here too so strobes drop immediately, not at the edge.
        if (!rst && bus.Enable && !halted_q) begin
            case (state_q)
                StT0: begin
                    bus.PCOut = 1'b1;
                    bus.MARIn = 1'b1;
                end
                StT1: begin
                    bus.RAMOut = 1'b1;
                    bus.IRIn   = 1'b1;
                    bus.PCInc  = 1'b1;
                end
                StT2: begin
                    case (bus.Opcode)
                        OpLda, OpAdd, OpSub, OpSta: begin
                            bus.IROut = 1'b1;
                            bus.MARIn = 1'b1;
                        end
                        OpLdi: begin
                            bus.IROut = 1'b1;
                            bus.AIn   = 1'b1;
                        end
                        OpJmp: begin
                            bus.IROut  = 1'b1;
                            bus.PCLoad = 1'b1;
                        end
                        OpJc: begin
                            bus.IROut  = 1'b1;
                            bus.PCLoad = bus.Flags[0];
                        end
                        OpJz: begin
                            bus.IROut  = 1'b1;
                            bus.PCLoad = bus.Flags[1];
                        end
                        OpInc, OpDcr: begin
                            bus.ALUOut    = 1'b1;
                            bus.AIn       = 1'b1;
                            bus.FlagsIn   = 1'b1;
                            bus.Operation = (bus.Opcode == OpInc) ? 2'b10 : 2'b11;
                        end
                        OpOut: begin
                            bus.AOut  = 1'b1;
                            bus.OutIn = 1'b1;
                        end
                        default: ;
                    endcase
                end
                StT3: begin
                    case (bus.Opcode)
                        OpLda: begin
                            bus.RAMOut = 1'b1;
                            bus.AIn    = 1'b1;
                        end
                        OpAdd, OpSub: begin
                            bus.RAMOut = 1'b1;
                            bus.BIn    = 1'b1;
                        end
                        OpSta: begin
                            bus.AOut  = 1'b1;
                            bus.RAMIn = 1'b1;
                        end
                        default: ;
                    endcase
                end
                StT4: begin
                    if (bus.Opcode == OpAdd || bus.Opcode == OpSub) begin
                        bus.ALUOut    = 1'b1;
                        bus.AIn       = 1'b1;
                        bus.FlagsIn   = 1'b1;
                        bus.Operation = (bus.Opcode == OpSub) ? 2'b01 : 2'b00;
                    end
                end
                default: ;
            endcase
        end
    end

    logic unused_nop;
    assign unused_nop = (OpNop == 4'b0000);

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Bench for sap_control_sequencer: per-opcode vector table plus hand-written
// stall, async-reset and halt sequences, checked through a scoreboard queue.
module tb_sap_control_sequencer;

    localparam logic [15:0] PCOUT   = 16'h8000;
    localparam logic [15:0] PCINC   = 16'h4000;
    localparam logic [15:0] PCLOAD  = 16'h2000;
    localparam logic [15:0] MARIN   = 16'h1000;
    localparam logic [15:0] RAMOUT  = 16'h0800;
    localparam logic [15:0] RAMIN   = 16'h0400;
    localparam logic [15:0] IRIN    = 16'h0200;
    localparam logic [15:0] IROUT   = 16'h0100;
    localparam logic [15:0] AIN     = 16'h0080;
    localparam logic [15:0] AOUT    = 16'h0040;
    localparam logic [15:0] BIN     = 16'h0020;
    localparam logic [15:0] ALUOUT  = 16'h0010;
    localparam logic [15:0] OP_SUB  = 16'h0004;
    localparam logic [15:0] OP_INC  = 16'h0008;
    localparam logic [15:0] OP_DCR  = 16'h000C;
    localparam logic [15:0] FLAGSIN = 16'h0002;
    localparam logic [15:0] OUTIN   = 16'h0001;
    localparam logic [15:0] F0      = PCOUT | MARIN;
    localparam logic [15:0] F1      = RAMOUT | IRIN | PCINC;

    typedef struct {
        logic [3:0]       op;
        logic [1:0]       fl;
        int               ncyc;
        logic [4:0][15:0] exp;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [19:0] sb_q[$];
    vec_t vecs[19];

    sap_control_sequencer_if bus ();

    sap_control_sequencer #(.NUM_T(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [3:0] op, input logic [1:0] fl, input int n,
                                input logic [15:0] e2, input logic [15:0] e3,
                                input logic [15:0] e4);
        vec_t v;
        v.op     = op;
        v.fl     = fl;
        v.ncyc   = n;
        v.exp[0] = F0;
        v.exp[1] = F1;
        v.exp[2] = e2;
        v.exp[3] = e3;
        v.exp[4] = e4;
        return v;
    endfunction

    function automatic logic [19:0] observed();
        return {bus.Halt, bus.TState, bus.PCOut, bus.PCInc, bus.PCLoad, bus.MARIn,
                bus.RAMOut, bus.RAMIn, bus.IRIn, bus.IROut, bus.AIn, bus.AOut, bus.BIn,
                bus.ALUOut, bus.Operation, bus.FlagsIn, bus.OutIn};
    endfunction

    // Pop the oldest expectation and compare it with what the DUT shows now.
    task automatic check_now(input string name);
        logic [19:0] expv;
        logic [19:0] got;
        expv = sb_q.pop_front();
        got  = observed();
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got halt=%b t=%0d strobes=%h, want halt=%b t=%0d strobes=%h",
                     name, got[19], got[18:16], got[15:0], expv[19], expv[18:16], expv[15:0]);
        end
    endtask

    // One clock: expectation queued, sampled on the falling edge, then advance.
    task automatic step(input string name, input logic [19:0] expv);
        sb_q.push_back(expv);
        @(negedge clk);
        check_now(name);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        checks++;
        if ($countones({bus.PCOut, bus.RAMOut, bus.IROut, bus.AOut, bus.ALUOut}) > 1) begin
            errors++;
            $display("FAIL bus_excl: drivers=%b, want at most one",
                     {bus.PCOut, bus.RAMOut, bus.IROut, bus.AOut, bus.ALUOut});
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(4'b0101, 2'b00, 3, IROUT | AIN, 16'h0, 16'h0);
        vecs[1]  = mk(4'b0000, 2'b00, 3, 16'h0, 16'h0, 16'h0);
        vecs[2]  = mk(4'b0001, 2'b00, 4, IROUT | MARIN, RAMOUT | AIN, 16'h0);
        vecs[3]  = mk(4'b0010, 2'b11, 5, IROUT | MARIN, RAMOUT | BIN, ALUOUT | AIN | FLAGSIN);
        vecs[4]  = mk(4'b0011, 2'b00, 5, IROUT | MARIN, RAMOUT | BIN,
                      ALUOUT | AIN | FLAGSIN | OP_SUB);
        vecs[5]  = mk(4'b0100, 2'b00, 4, IROUT | MARIN, AOUT | RAMIN, 16'h0);
        vecs[6]  = mk(4'b0110, 2'b00, 3, IROUT | PCLOAD, 16'h0, 16'h0);
        vecs[7]  = mk(4'b0111, 2'b01, 3, IROUT | PCLOAD, 16'h0, 16'h0);
        vecs[8]  = mk(4'b0111, 2'b00, 3, IROUT, 16'h0, 16'h0);
        vecs[9]  = mk(4'b0111, 2'b10, 3, IROUT, 16'h0, 16'h0);
        vecs[10] = mk(4'b1000, 2'b10, 3, IROUT | PCLOAD, 16'h0, 16'h0);
        vecs[11] = mk(4'b1000, 2'b00, 3, IROUT, 16'h0, 16'h0);
        vecs[12] = mk(4'b1000, 2'b01, 3, IROUT, 16'h0, 16'h0);
        vecs[13] = mk(4'b1001, 2'b00, 3, ALUOUT | AIN | FLAGSIN | OP_INC, 16'h0, 16'h0);
        vecs[14] = mk(4'b1010, 2'b00, 3, ALUOUT | AIN | FLAGSIN | OP_DCR, 16'h0, 16'h0);
        vecs[15] = mk(4'b1110, 2'b00, 3, AOUT | OUTIN, 16'h0, 16'h0);
        vecs[16] = mk(4'b1011, 2'b00, 3, 16'h0, 16'h0, 16'h0);
        vecs[17] = mk(4'b1100, 2'b00, 3, 16'h0, 16'h0, 16'h0);
        vecs[18] = mk(4'b1101, 2'b00, 3, 16'h0, 16'h0, 16'h0);

        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        bus.Enable = 1'b1;
        bus.Opcode = 4'b0000;
        bus.Flags  = 2'b00;

        #2;
        sb_q.push_back(20'h0);
        check_now("reset_state");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Back-to-back instructions: each must start at T0 exactly ncyc clocks later.
        foreach (vecs[i]) begin
            bus.Opcode = vecs[i].op;
            bus.Flags  = vecs[i].fl;
            for (int c = 0; c < vecs[i].ncyc; c++) begin
                step($sformatf("op%b_fl%b_t%0d", vecs[i].op, vecs[i].fl, c),
                     {1'b0, 3'(c), vecs[i].exp[c]});
            end
        end

        // LDA stalled at T3 by Enable=0.
        bus.Opcode = 4'b0001;
        step("lda_t0", {1'b0, 3'd0, F0});
        step("lda_t1", {1'b0, 3'd1, F1});
        step("lda_t2", {1'b0, 3'd2, IROUT | MARIN});
        bus.Enable = 1'b0;
        for (int k = 0; k < 3; k++) step("lda_stall", {1'b0, 3'd3, 16'h0});
        bus.Enable = 1'b1;
        step("lda_t3", {1'b0, 3'd3, RAMOUT | AIN});
        step("lda_next_t0", {1'b0, 3'd0, F0});
        step("lda2_t1", {1'b0, 3'd1, F1});
        step("lda2_t2", {1'b0, 3'd2, IROUT | MARIN});
        step("lda2_t3", {1'b0, 3'd3, RAMOUT | AIN});

        // Async reset in the middle of ADD T3.
        bus.Opcode = 4'b0010;
        step("add_t0", {1'b0, 3'd0, F0});
        step("add_t1", {1'b0, 3'd1, F1});
        step("add_t2", {1'b0, 3'd2, IROUT | MARIN});
        sb_q.push_back({1'b0, 3'd3, RAMOUT | BIN});
        check_now("add_t3_pre_rst");
        #1;
        rst = 1'b1;
        #1;
        sb_q.push_back(20'h0);
        check_now("rst_async_mid_add");
        @(posedge clk);
        #1;
        rst = 1'b0;

        bus.Opcode = 4'b1100;
        step("nop1100_t0", {1'b0, 3'd0, F0});
        step("nop1100_t1", {1'b0, 3'd1, F1});
        step("nop1100_t2", {1'b0, 3'd2, 16'h0});
        bus.Opcode = 4'b0101;
        step("ldi_t0", {1'b0, 3'd0, F0});
        step("ldi_t1", {1'b0, 3'd1, F1});
        step("ldi_t2", {1'b0, 3'd2, IROUT | AIN});

        // HLT: sticky halt regardless of Enable, cleared only by reset.
        bus.Opcode = 4'b1111;
        step("hlt_t0", {1'b0, 3'd0, F0});
        step("hlt_t1", {1'b0, 3'd1, F1});
        step("hlt_t2", {1'b0, 3'd2, 16'h0});
        for (int k = 0; k < 20; k++) begin
            bus.Enable = 1'($urandom_range(0, 1));
            bus.Opcode = 4'($urandom_range(0, 15));
            step("halted", {1'b1, 3'd0, 16'h0});
        end
        rst = 1'b1;
        #1;
        sb_q.push_back(20'h0);
        check_now("halt_cleared_by_rst");
        @(posedge clk);
        #1;
        rst        = 1'b0;
        bus.Enable = 1'b1;
        bus.Opcode = 4'b0101;
        step("post_halt_t0", {1'b0, 3'd0, F0});
        step("post_halt_t1", {1'b0, 3'd1, F1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sap_control_sequencer.md
Name: sap_control_sequencer

Overview:
Fetch/decode/execute controller for the 8-bit SAP datapath. It steps through the T-states and decodes the instruction-register opcode. It drives every bus-control strobe, including the ALU Operation select and ALUOut enable. It sits directly upstream of the ALU and issues the controls that make the ALU drive the bus and the flags register latch the ALU Zero/Carry flags.

Parameters:
NUM_T, 6, number of T-states in the ring (T0..T5); execute steps never exceed T4.

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  asynchronous, active-high reset
Enable  input  1  1 = sequencer advances each clock; 0 = hold state and force all strobes to 0
Opcode  input  4  upper nibble of instruction register
Flags  input  2  registered {Zero,Carry} from flags register
PCOut  output  1  program counter drives bus
PCInc  output  1  program counter increments
PCLoad  output  1  program counter loads from bus (jump)
MARIn  output  1  memory address register loads from bus
RAMOut  output  1  RAM drives bus
RAMIn  output  1  RAM writes from bus
IRIn  output  1  instruction register loads from bus
IROut  output  1  IR operand nibble drives bus
AIn  output  1  accumulator loads from bus
AOut  output  1  accumulator drives bus
BIn  output  1  B register loads from bus
ALUOut  output  1  ALU drives bus
Operation  output  2  ALU op: 00 ADD, 01 SUB, 10 INC, 11 DCR
FlagsIn  output  1  flags register latches ALU Zero/Carry
OutIn  output  1  output register loads from bus
Halt  output  1  processor halted (clock-gate request)
TState  output  3  current T-state index, for debug display

Behaviour:
- State: TState register (0..5) and Halted flag.
- Reset (async, rst=1): TState=0, Halted=0. While rst=1, all strobes=0, Operation=00, Halt=0.
- Strobes are combinational decode of (TState, Opcode, Flags, Halted, Enable). Any strobe not listed for a step is 0. Operation=00 unless the step lists otherwise.
- Enable=0: TState and Halted hold; all strobes=0; TState output still valid.
- Fetch, all opcodes:
  - T0: PCOut, MARIn.
  - T1: RAMOut, IRIn, PCInc.
  - Opcode is valid from T2 onward and must be stable through the last execute step.
- Execute steps. "end" means the next clock sets TState=0, giving variable-length instructions.
  - 0000 NOP: T2 none; end.
  - 0001 LDA: T2 IROut,MARIn; T3 RAMOut,AIn; end.
  - 0010 ADD: T2 IROut,MARIn; T3 RAMOut,BIn; T4 ALUOut,AIn,FlagsIn,Operation=00; end.
  - 0011 SUB: as ADD, but Operation=01 at T4.
  - 0100 STA: T2 IROut,MARIn; T3 AOut,RAMIn; end.
  - 0101 LDI: T2 IROut,AIn; end.
  - 0110 JMP: T2 IROut,PCLoad; end.
  - 0111 JC: T2 IROut; PCLoad=Flags[0]; end.
  - 1000 JZ: T2 IROut; PCLoad=Flags[1]; end.
  - 1001 INC: T2 ALUOut,AIn,FlagsIn,Operation=10; end.
  - 1010 DCR: T2 ALUOut,AIn,FlagsIn,Operation=11; end.
  - 1110 OUT: T2 AOut,OutIn; end.
  - 1111 HLT: T2 no strobes. On the clock edge ending T2, Halted=1 and TState=0.
  - 1011, 1100, 1101: treated as NOP.
- Halted=1:
  - Halt=1 and all strobes=0.
  - TState stays 0 regardless of Enable.
  - Only rst clears Halted.
- Jumps: Flags are sampled combinationally during T2 and reflect the last FlagsIn update. PCLoad and PCInc are never asserted together.
- Cycle counts (clocks per instruction, including fetch):
  - 3: NOP, LDI, JMP, JC, JZ, INC, DCR, OUT.
  - 4: LDA, STA.
  - 5: ADD, SUB.
  - HLT halts after 3 clocks.
- TState never reaches 5 in legal operation. If TState=5 is ever reached, it returns to 0 next clock with no strobes.
- Bus exclusivity: at most one of PCOut, RAMOut, IROut, AOut, ALUOut is 1 in any cycle. This is an assertion the bench must check every cycle.
- Reset mid-instruction: async return to T0 with strobes low immediately. Fetch restarts on the first clock after rst deasserts.

Test Plan:
- Reset then Enable=1, Opcode=0101 → cycle T0 PCOut=MARIn=1, T1 RAMOut=IRIn=PCInc=1, T2 IROut=AIn=1, then TState=0.
- Opcode=0010 → T4 shows ALUOut=AIn=FlagsIn=1, Operation=00; Opcode=0011 → same with Operation=01; 5 clocks per instruction.
- Opcode=0111 with Flags=01 → PCLoad=1 at T2; Flags=00 → PCLoad=0; Opcode=1000 with Flags=10 → PCLoad=1.
- Opcode=1111 → Halt=1 after T2 edge, TState held 0, strobes 0 for 20 clocks, cleared only by rst.
- Enable=0 during T3 of LDA → TState holds 3, all strobes 0. Enable=1 → RAMOut=AIn=1, then T0.
- rst pulsed asynchronously mid-T3 of ADD → TState=0 and all strobes 0 before the next edge. Opcode=1100 → behaves as NOP (3 clocks); bus-exclusivity assertion holds throughout.
